// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 1R1W memory arbiter.
// Holds the FSM state encoding, the grant identifier and the default RAM
// word-address width. Also provides a helper that expands byte enables to a bit mask.
package mem_arb_pkg;

  localparam int RAM_AW_DEFAULT = 12;

  // RMW_RD names the read half of a partial write. That half runs in the grant
  // cycle while the register still holds IDLE, so the register never holds RMW_RD.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    RMW_RD  = 2'd2,
    RMW_WR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  // Expand a 4-bit byte enable into a 32-bit lane mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int n = 0; n < 4; n++) begin
      mask[8*n +: 8] = {8{be[n]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_arb_byte_merge.sv
// Combinational byte-lane merge for read-modify-write.
// Enabled lanes are taken from new_word. Disabled lanes keep old_word.
module mem_arb_byte_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged_word
);

  logic [31:0] lane_mask;

  assign lane_mask   = be_to_mask(be);
  assign merged_word = (old_word & ~lane_mask) | (new_word & lane_mask);

endmodule

// File: rtl/mem_arbiter_1r1w.sv
// Single-port RAM arbiter for a CPU instruction port and a CPU data port.
// Both ports use an Avalon-style waitrequest handshake. The arbiter serialises
// requests and emulates byte-enable writes with a read-modify-write sequence.
// Optional feature: define MEM_ARB_RR_EN for round-robin grant on contention.
// Without it, the data port has fixed priority over the instruction port.
module mem_arbiter_1r1w
  import mem_arb_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  // data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_address,
  input  logic [31:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  // RAM side
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_write,
  output logic              ram_read,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata
);

  arb_state_t        state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic              d_req, i_req;
  logic              grant_data;
  logic              be_full, be_none;
  logic [RAM_AW-1:0] d_word, i_word;
  logic [31:0]       merged_word;

  // The byte-offset bits and the bits above the RAM window are dropped, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_address[31:RAM_AW+2], d_address[1:0],
                              i_address[31:RAM_AW+2], i_address[1:0]};

  assign d_word  = d_address[RAM_AW+1:2];
  assign i_word  = i_address[RAM_AW+1:2];
  assign d_req   = d_read | d_write;
  assign i_req   = i_read;
  assign be_full = &d_byteenable;
  assign be_none = ~|d_byteenable;

`ifdef MEM_ARB_RR_EN
  gnt_t last_grant_q;

  // On contention, grant the port that was not granted last.
  assign grant_data = d_req && (!i_req || (last_grant_q == GNT_INSTR));

  // Record the winner of every grant made in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GNT_INSTR;
    end else if ((state_q == IDLE) && (d_req || i_req)) begin
      last_grant_q <= grant_data ? GNT_DATA : GNT_INSTR;
    end
  end
`else
  // Fixed priority: the data port always wins.
  assign grant_data = d_req;
`endif

  mem_arb_byte_merge u_merge (
    .old_word    (ram_readdata),
    .new_word    (d_writedata),
    .be          (d_byteenable),
    .merged_word (merged_word)
  );

  // Next-state and output decode. Outputs are forced idle while reset is high.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    state_d       = state_q;
    gnt_d         = gnt_q;
    ram_address   = d_word;
    ram_write     = 1'b0;
    ram_read      = 1'b0;
    ram_writedata = d_writedata;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          gnt_d       = GNT_DATA;
          ram_address = d_word;
          // A simultaneous read and write is handled as a write.
          if (d_write) begin
            if (be_full) begin
              ram_write     = 1'b1;
              d_waitrequest = 1'b0;
            end else if (be_none) begin
              d_waitrequest = 1'b0;
            end else begin
              ram_read = 1'b1;
              state_d  = RMW_WR;
            end
          end else begin
            ram_read = 1'b1;
            state_d  = RD_DATA;
          end
        end else if (i_req) begin
          gnt_d       = GNT_INSTR;
          ram_address = i_word;
          ram_read    = 1'b1;
          state_d     = RD_DATA;
        end
      end

      RD_DATA: begin
        state_d = IDLE;
        if (gnt_q == GNT_DATA) begin
          ram_address   = d_word;
          d_waitrequest = 1'b0;
          d_readdata    = ram_readdata;
        end else begin
          ram_address   = i_word;
          i_waitrequest = 1'b0;
          i_readdata    = ram_readdata;
        end
      end

      RMW_WR: begin
        ram_address   = d_word;
        ram_writedata = merged_word;
        ram_write     = 1'b1;
        d_waitrequest = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      ram_write     = 1'b0;
      ram_read      = 1'b0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;
    end
  end

  // State and granted-port registers. Reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment, so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_INSTR;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

`ifndef SYNTHESIS
  // The data master must not assert read and write together.
  rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_mem_arbiter_1r1w.sv
// Self-checking bench for mem_arbiter_1r1w.
// Drivers push the expected responses into a queue. A negedge monitor pops
// one entry and compares it whenever either port completes.
module tb_mem_arbiter_1r1w;

  localparam int RAM_AW = 12;
  localparam int MAXW   = 40;

  typedef struct {
    logic        port;   // 0 = instruction, 1 = data
    logic        wr;
    logic [31:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [31:0]       i_address;
  logic              i_waitrequest;
  logic [31:0]       i_readdata;
  logic              d_read, d_write;
  logic [3:0]        d_byteenable;
  logic [31:0]       d_address, d_writedata;
  logic              d_waitrequest;
  logic [31:0]       d_readdata;
  logic [RAM_AW-1:0] ram_address;
  logic              ram_write, ram_read;
  logic [31:0]       ram_writedata;
  logic [31:0]       ram_readdata;

  logic [31:0] mem [0:(1<<RAM_AW)-1];
  resp_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_ram_writes = 0;
  int          n_ram_reads  = 0;

  always #5 clk = ~clk;

  mem_arbiter_1r1w #(.RAM_AW(RAM_AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_byteenable  (d_byteenable),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .ram_address   (ram_address),
    .ram_write     (ram_write),
    .ram_read      (ram_read),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  // RAM model: registered read of the old word, write at the same edge.
  always @(posedge clk) begin
    ram_readdata <= mem[ram_address];
    if (ram_write) mem[ram_address] = ram_writedata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic push(input logic port, input logic wr, input logic [31:0] data);
    resp_t e;
    e.port = port;
    e.wr   = wr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic compare(input logic port, input logic wr, input logic [31:0] data);
    resp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_response: port %0d wr %0d data 0x%08h, nothing expected", port, wr, data);
    end else begin
      e = exp_q.pop_front();
      check("resp_port", {31'b0, port}, {31'b0, e.port});
      check("resp_kind", {31'b0, wr}, {31'b0, e.wr});
      if (!wr) check("resp_data", data, e.data);
    end
  endtask

  // Monitor: compare every completion against the scoreboard and count RAM strobes.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_read && !i_waitrequest) compare(1'b0, 1'b0, i_readdata);
      if ((d_read || d_write) && !d_waitrequest) compare(1'b1, d_write, d_readdata);
    end
    if (ram_write) n_ram_writes++;
    if (ram_read)  n_ram_reads++;
  end

  // Fetch master. Callers start at posedge + 1.
  task automatic do_i(input logic [31:0] addr, output int waits);
    i_read    = 1'b1;
    i_address = addr;
    waits     = 0;
    @(negedge clk);
    while (i_waitrequest && waits < MAXW) begin
      waits++;
      @(negedge clk);
    end
    if (i_waitrequest) begin
      n_checks++;
      $display("FAIL i_timeout: waitrequest still high after %0d cycles, required low", waits);
    end
    @(posedge clk);
    #1 i_read = 1'b0;
  endtask

  // Data master. Callers start at posedge + 1.
  task automatic do_d(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] data, output int waits);
    d_read       = !wr;
    d_write      = wr;
    d_byteenable = be;
    d_address    = addr;
    d_writedata  = data;
    waits        = 0;
    @(negedge clk);
    while (d_waitrequest && waits < MAXW) begin
      waits++;
      @(negedge clk);
    end
    if (d_waitrequest) begin
      n_checks++;
      $display("FAIL d_timeout: waitrequest still high after %0d cycles, required low", waits);
    end
    @(posedge clk);
    #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, wb;
    for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = 32'h0;
    mem[0]  = 32'hCAFE_0001;
    mem[4]  = 32'h2402_0005;
    mem[17] = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      mem[32+i] = 32'hD000_0020 + i;
      mem[40+i] = 32'h1000_0040 + i;
    end

    // Reset with requests pending: everything must stay idle.
    reset = 1'b1;
    i_read = 1'b1; i_address = 32'h10;
    d_read = 1'b0; d_write = 1'b1; d_byteenable = 4'hF;
    d_address = 32'hFFC; d_writedata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    check("rst_i_waitrequest", {31'b0, i_waitrequest}, 32'd1);
    check("rst_d_waitrequest", {31'b0, d_waitrequest}, 32'd1);
    check("rst_ram_write",     {31'b0, ram_write},     32'd0);
    check("rst_i_readdata",    i_readdata, 32'h0);
    check("rst_d_readdata",    d_readdata, 32'h0);
    @(posedge clk);
    #1;
    i_read = 1'b0; d_write = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_no_ram_writes", n_ram_writes, 32'd0);

    // Fetch only.
    push(1'b0, 1'b0, 32'h2402_0005);
    do_i(32'h0000_0010, w);
    check("fetch_wait_cycles", w, 32'd1);

    // Full-word write, then read back.
    wb = n_ram_writes;
    push(1'b1, 1'b1, 32'h0);
    do_d(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, w);
    check("full_wr_wait", w, 32'd0);
    check("full_wr_ram_writes", n_ram_writes - wb, 32'd1);
    check("full_wr_mem", mem[16], 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    do_d(1'b0, 4'h0, 32'h40, 32'h0, w);
    check("d_read_wait", w, 32'd1);

    // Partial write via read-modify-write.
    mem[16] = 32'h1122_3344;
    wb = n_ram_writes;
    push(1'b1, 1'b1, 32'h0);
    do_d(1'b1, 4'b0010, 32'h40, 32'h0000_AA00, w);
    check("rmw_wait", w, 32'd1);
    check("rmw_ram_writes", n_ram_writes - wb, 32'd1);
    check("rmw_mem", mem[16], 32'h1122_AA44);
    push(1'b1, 1'b0, 32'h1122_AA44);
    do_d(1'b0, 4'h0, 32'h40, 32'h0, w);

    // Empty byte enable: immediate completion with no RAM write.
    wb = n_ram_writes;
    push(1'b1, 1'b1, 32'h0);
    do_d(1'b1, 4'h0, 32'h44, 32'hFFFF_FFFF, w);
    check("be0_wait", w, 32'd0);
    check("be0_ram_writes", n_ram_writes - wb, 32'd0);
    check("be0_mem", mem[17], 32'h5555_AAAA);

    // Data write then fetch of the same word returns the new value.
    push(1'b1, 1'b1, 32'h0);
    do_d(1'b1, 4'hF, 32'h48, 32'h0BAD_F00D, w);
    push(1'b0, 1'b0, 32'h0BAD_F00D);
    do_i(32'h48, w);

    // Aliased, misaligned address maps to word 0.
    push(1'b1, 1'b0, 32'hCAFE_0001);
    do_d(1'b0, 4'h0, 32'h0000_4002, 32'h0, w);
    check("alias_wait", w, 32'd1);

    // Reset during the read half of a partial write.
    wb = n_ram_writes;
    d_write = 1'b1; d_byteenable = 4'b0100; d_address = 32'h40; d_writedata = 32'h0077_0000;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rmw_rst_i_wait",    {31'b0, i_waitrequest}, 32'd1);
    check("rmw_rst_d_wait",    {31'b0, d_waitrequest}, 32'd1);
    check("rmw_rst_ram_write", {31'b0, ram_write},     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; d_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rmw_rst_ram_writes", n_ram_writes - wb, 32'd0);
    check("rmw_rst_mem", mem[16], 32'h1122_AA44);
    push(1'b0, 1'b0, 32'h1122_AA44);
    do_i(32'h40, w);
    check("post_rst_fetch_wait", w, 32'd1);

    // Contention: both masters request back to back.
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 32'hD000_0020 + i);
      push(1'b0, 1'b0, 32'h1000_0040 + i);
    end
`else
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 32'hD000_0020 + i);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 32'h1000_0040 + i);
`endif
    fork
      begin
        int wd;
        for (int i = 0; i < 3; i++) do_d(1'b0, 4'h0, 32'h80 + 4*i, 32'h0, wd);
      end
      begin
        int wi;
        for (int i = 0; i < 3; i++) do_i(32'hA0 + 4*i, wi);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
